shift_seq: RTL and testbench
============================

SHIFT_SEQ -- requirements
Module: shift_seq

Interface
- REQ-001 SHALL have parameter STEP, default 1, giving the maximum bit positions shifted per cycle; legal values are 1, 2 and 4.
- REQ-002 SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
- REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
- REQ-004 SHALL have port start, input, 1 bit: request a shift; accepted only while ready=1.
- REQ-005 SHALL have port op, input, 2 bits: 00 SLL, 01 SRL, 10 SRA, 11 reserved; sampled on acceptance.
- REQ-006 SHALL have port operand, input, 32 bits: value to shift; sampled on acceptance.
- REQ-007 SHALL have port shamt, input, 5 bits: shift amount 0..31; sampled on acceptance.
- REQ-008 SHALL have port flush, input, 1 bit: synchronous abort of any in-flight operation.
- REQ-009 SHALL have port ready, output, 1 bit: high when a start can be accepted this cycle.
- REQ-010 SHALL have port busy, output, 1 bit: high while state is SHIFT.
- REQ-011 SHALL have port done, output, 1 bit: single-cycle completion pulse.
- REQ-012 SHALL have port err, output, 1 bit: high with done when the completed op was 11.
- REQ-013 SHALL have port result, output, 32 bits: shifted value, valid from done and held until the next acceptance.

Function
- REQ-014 SHALL implement states IDLE, SHIFT and DONE; ready=1 in IDLE and DONE, 0 in SHIFT.
- REQ-015 SHALL accept on a rising edge with start=1, ready=1 and flush=0, loading operand into the working register, op, and shamt into the remaining-count register.
- REQ-016 On acceptance, SHALL go to DONE if shamt=0 or op=11, otherwise to SHIFT.
- REQ-017 In SHIFT, each cycle SHALL shift the working register by k=min(STEP, remaining) and decrement remaining by k.
- REQ-018 SHALL implement SLL as zero-fill from the LSB, SRL as zero-fill from the MSB, and SRA as fill with the bit-31 value captured at acceptance.
- REQ-019 SHALL leave SHIFT for DONE on the edge where remaining reaches 0.
- REQ-020 SHALL assert done for exactly the one cycle in DONE, with result equal to the working register.
- REQ-021 From DONE, SHALL go to SHIFT or DONE on an accepted start (back-to-back), otherwise to IDLE.
- REQ-022 SHALL have latency, from acceptance edge to done-high cycle, of ceil(shamt/STEP)+1 cycles; shamt=0 or op=11 gives 1 cycle.
- REQ-023 SHALL ignore start when ready=0, with no queuing.
- REQ-024 For op=11, SHALL produce result=operand unchanged and err=1 in the DONE cycle; err is 0 in all other cycles.
- REQ-025 Flush=1 on any edge SHALL force IDLE with no done pulse; flush takes priority over start on the same edge.
- REQ-026 Flush SHALL leave result holding the last completed value; the working register is not exposed until DONE.
- REQ-027 Result SHALL change only at DONE entry and SHALL be stable in IDLE and SHIFT.

Reset
- REQ-028 rst_n=0 SHALL immediately force state IDLE, result=0, remaining=0, done=0, err=0, busy=0 and ready=1, regardless of clk.
- REQ-029 Reset asserted mid-SHIFT SHALL discard the operation with no done pulse.
- REQ-030 After reset, SHALL accept a start on the first rising edge with rst_n=1.

Verification
- REQ-031 SLL, operand 0x00000001, shamt 31, STEP=1 -> busy for 31 cycles; done in cycle 32 after acceptance; result 0x80000000.
- REQ-032 SRA, 0x80000000, shamt 4 -> result 0xF8000000; SRL with the same inputs -> 0x08000000; with STEP=4 each completes with done 2 cycles after acceptance.
- REQ-033 shamt=0, operand 0xDEADBEEF, any legal op -> done 1 cycle after acceptance; result 0xDEADBEEF; busy never high; op=11 -> same result and err=1.
- REQ-034 Start SRL 0xF0000000 by 8, flush on the 3rd SHIFT cycle -> no done pulse, result keeps its prior value, ready=1 next cycle.
- REQ-035 Back-to-back: start asserted in the DONE cycle -> accepted; second done at its own latency; first result visible for exactly one DONE cycle before the hold.
- REQ-036 rst_n pulsed low mid-SHIFT, between clock edges -> outputs reach reset values immediately; no done pulse; a new op completes correctly afterward.

Source files
------------

// File: rtl/shift_seq.sv
// shift_seq: multi-cycle sequential barrel-less shifter.
// Shifts a 32-bit operand by up to STEP bit positions per clock until the
// requested amount is consumed, then pulses done for one cycle with the result.
//
// Parameters
//   STEP     max bit positions shifted per cycle (1, 2 or 4)
// Ports
//   clk      clock, rising edge
//   rst_n    async active-low reset
//   start    shift request, taken when ready=1 and flush=0
//   op       00 SLL, 01 SRL, 10 SRA, 11 reserved (passes operand, flags err)
//   operand  value to shift
//   shamt    shift amount 0..31
//   flush    synchronous abort, wins over start
//   ready    a start can be taken this cycle (IDLE or DONE)
//   busy     operation in progress (SHIFT)
//   done     one-cycle completion pulse
//   err      with done, completed op was reserved
//   result   last completed value, updated only on DONE entry
module shift_seq #(
  parameter int STEP = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] operand,
  input  logic [4:0]  shamt,
  input  logic        flush,
  output logic        ready,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] result
);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  localparam logic [4:0] STEP_AMT = 5'(STEP);

  state_t      r_state, w_state_nxt;
  logic [31:0] r_work, r_result;
  logic [1:0]  r_op;
  logic [4:0]  r_rem;
  logic        r_fill;

  logic        w_accept, w_direct;
  logic [4:0]  w_k, w_rem_nxt;
  logic [31:0] w_shifted;

  assign ready    = (r_state != S_SHIFT);
  assign busy     = (r_state == S_SHIFT);
  assign done     = (r_state == S_DONE);
  assign err      = done & (r_op == 2'b11);
  assign result   = r_result;

  assign w_accept = start & ready & ~flush;
  // Zero shift and the reserved op complete without visiting SHIFT.
  assign w_direct = (shamt == 5'd0) | (op == 2'b11);

  assign w_k       = (r_rem < STEP_AMT) ? r_rem : STEP_AMT;
  assign w_rem_nxt = r_rem - w_k;

  always_comb begin
    w_shifted = r_work;
    case (r_op)
      2'b00:   w_shifted = r_work << w_k;
      2'b01:   w_shifted = r_work >> w_k;
      // SRA fills with the sign captured at acceptance, not the current MSB.
      default: w_shifted = (r_work >> w_k) |
                           (r_fill ? ~(32'hFFFF_FFFF >> w_k) : 32'h0);
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_accept)             w_state_nxt = w_direct ? S_DONE : S_SHIFT;
          else if (r_state == S_DONE) w_state_nxt = S_IDLE;
        end
        S_SHIFT: if (w_rem_nxt == 5'd0) w_state_nxt = S_DONE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_work   <= '0;
      r_result <= '0;
      r_op     <= '0;
      r_rem    <= '0;
      r_fill   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_work <= operand;
        r_op   <= op;
        r_rem  <= shamt;
        r_fill <= operand[31];
        if (w_direct) r_result <= operand;
      end else if (r_state == S_SHIFT && !flush) begin
        r_work <= w_shifted;
        r_rem  <= w_rem_nxt;
        // result is published only on the edge that enters DONE
        if (w_rem_nxt == 5'd0) r_result <= w_shifted;
      end
    end
  end

endmodule

// File: tb/tb_shift_seq.sv
// tb_shift_seq: directed bench for shift_seq. Two instances (STEP=1 and
// STEP=4) share operands/op/flush/reset but have separate start strobes.
module tb_shift_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start1, start4, flush;
  logic [1:0]  op;
  logic [31:0] operand;
  logic [4:0]  shamt;
  logic        ready1, busy1, done1, err1;
  logic        ready4, busy4, done4, err4;
  logic [31:0] result1, result4;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  shift_seq #(.STEP(1)) u_s1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .op(op), .operand(operand),
    .shamt(shamt), .flush(flush), .ready(ready1), .busy(busy1), .done(done1),
    .err(err1), .result(result1));

  shift_seq #(.STEP(4)) u_s4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .op(op), .operand(operand),
    .shamt(shamt), .flush(flush), .ready(ready4), .busy(busy4), .done(done4),
    .err(err4), .result(result4));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // Issue one op to both instances and measure latency/busy/err/result.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [4:0] s, input logic [31:0] exp,
                        input int l1, input int l4);
    int c1, c4, b1, e1, e4;
    logic [31:0] r1, r4;
    c1 = 0; c4 = 0; b1 = 0; e1 = 0; e4 = 0; r1 = '0; r4 = '0;
    @(negedge clk);
    op = o; operand = a; shamt = s; start1 = 1'b1; start4 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0; start4 = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      if (busy1) b1++;
      if (err1)  e1++;
      if (err4)  e4++;
      if (done1 && c1 == 0) begin c1 = n; r1 = result1; end
      if (done4 && c4 == 0) begin c4 = n; r4 = result4; end
      if (c1 != 0 && c4 != 0) break;
      @(posedge clk); #1;
    end
    chk({tag, " lat1"},  32'(c1), 32'(l1));
    chk({tag, " lat4"},  32'(c4), 32'(l4));
    chk({tag, " res1"},  r1, exp);
    chk({tag, " res4"},  r4, exp);
    chk({tag, " busy1"}, 32'(b1), 32'(l1 - 1));
    chk({tag, " err1"},  32'(e1), (o == 2'b11) ? 32'd1 : 32'd0);
    chk({tag, " err4"},  32'(e4), (o == 2'b11) ? 32'd1 : 32'd0);
  endtask

  // Count cycles (starting at index n0) until done1, 0 on timeout.
  task automatic wait_done1(input int n0, output int lat);
    lat = 0;
    for (int n = n0; n <= 60; n++) begin
      if (done1) begin lat = n; return; end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int lat, dn;
    rst_n = 1'b0; start1 = 1'b0; start4 = 1'b0; flush = 1'b0;
    op = 2'b00; operand = '0; shamt = '0;
    @(posedge clk); @(posedge clk); #1;
    chk("rst ready1", 32'(ready1), 32'd1);
    chk("rst busy1",  32'(busy1),  32'd0);
    chk("rst done1",  32'(done1),  32'd0);
    chk("rst err1",   32'(err1),   32'd0);
    chk("rst res1",   result1,     32'h0);
    chk("rst ready4", 32'(ready4), 32'd1);
    chk("rst res4",   result4,     32'h0);
    @(negedge clk); rst_n = 1'b1;

    run_op("sll31",  2'b00, 32'h0000_0001, 5'd31, 32'h8000_0000, 32, 9);
    run_op("sra4",   2'b10, 32'h8000_0000, 5'd4,  32'hF800_0000, 5,  2);
    run_op("srl4",   2'b01, 32'h8000_0000, 5'd4,  32'h0800_0000, 5,  2);
    run_op("zero",   2'b00, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, 1,  1);
    run_op("zsra",   2'b10, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, 1,  1);
    run_op("rsv0",   2'b11, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, 1,  1);
    run_op("rsv5",   2'b11, 32'h1234_5678, 5'd5,  32'h1234_5678, 1,  1);
    run_op("srl7",   2'b01, 32'hFFFF_FFFF, 5'd7,  32'h01FF_FFFF, 8,  3);
    run_op("sra9",   2'b10, 32'h8000_00F0, 5'd9,  32'hFFC0_0000, 10, 4);
    run_op("sll13",  2'b00, 32'h0000_00AB, 5'd13, 32'h0015_6000, 14, 5);

    // Flush on the 3rd SHIFT cycle (STEP=1 instance only).
    @(negedge clk);
    op = 2'b01; operand = 32'hF000_0000; shamt = 5'd8; start1 = 1'b1;
    @(posedge clk); #1; start1 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("fl busy", 32'(busy1), 32'd1);
    flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    chk("fl ready", 32'(ready1), 32'd1);
    chk("fl busy0", 32'(busy1),  32'd0);
    chk("fl done",  32'(done1),  32'd0);
    chk("fl hold",  result1,     32'h0015_6000);
    dn = 0;
    for (int n = 0; n < 10; n++) begin
      if (done1) dn++;
      @(posedge clk); #1;
    end
    chk("fl nodone", 32'(dn), 32'd0);
    chk("fl hold2",  result1, 32'h0015_6000);

    // start while busy is dropped
    @(negedge clk);
    op = 2'b00; operand = 32'h0000_0003; shamt = 5'd4; start1 = 1'b1;
    @(posedge clk); #1; start1 = 1'b0;
    @(posedge clk); #1;
    op = 2'b11; operand = 32'hAAAA_AAAA; shamt = 5'd0; start1 = 1'b1;
    @(posedge clk); #1; start1 = 1'b0;
    wait_done1(3, lat);
    chk("ign lat", 32'(lat), 32'd5);
    chk("ign res", result1,  32'h0000_0030);
    chk("ign err", 32'(err1), 32'd0);

    // Back-to-back: second start issued during the DONE cycle.
    @(negedge clk);
    op = 2'b00; operand = 32'h0000_0001; shamt = 5'd2; start1 = 1'b1;
    @(posedge clk); #1; start1 = 1'b0;
    wait_done1(1, lat);
    chk("b2b lat1",  32'(lat),    32'd3);
    chk("b2b res1",  result1,     32'h0000_0004);
    chk("b2b ready", 32'(ready1), 32'd1);
    op = 2'b01; operand = 32'h0000_0080; shamt = 5'd3; start1 = 1'b1;
    @(posedge clk); #1; start1 = 1'b0;
    chk("b2b done0", 32'(done1), 32'd0);
    chk("b2b busy",  32'(busy1), 32'd1);
    chk("b2b hold",  result1,    32'h0000_0004);
    wait_done1(1, lat);
    chk("b2b lat2",  32'(lat),   32'd4);
    chk("b2b res2",  result1,    32'h0000_0010);

    // Async reset mid-SHIFT, between clock edges.
    @(negedge clk);
    op = 2'b00; operand = 32'h0000_0001; shamt = 5'd10; start1 = 1'b1; start4 = 1'b1;
    @(posedge clk); #1; start1 = 1'b0; start4 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("ar ready1", 32'(ready1), 32'd1);
    chk("ar busy1",  32'(busy1),  32'd0);
    chk("ar res1",   result1,     32'h0);
    chk("ar busy4",  32'(busy4),  32'd0);
    chk("ar res4",   result4,     32'h0);
    @(negedge clk); rst_n = 1'b1;
    dn = 0;
    for (int n = 0; n < 15; n++) begin
      @(posedge clk); #1;
      if (done1 || done4) dn++;
    end
    chk("ar nodone", 32'(dn), 32'd0);
    run_op("post", 2'b01, 32'h0000_00F0, 5'd4, 32'h0000_000F, 5, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
